// File: rtl/sspm_tdm_arbiter.sv
// sspm_tdm_arbiter: shared scratchpad back end for NCORES connectors.
// Each core parks one word request in a latch. A rotating TDM slot picks
// which core may touch the internal single-port word memory this cycle, and
// the served core sees a one-cycle io_select pulse with read data valid.
// Optional build macro: SSPM_SKIP_IDLE_EN makes the slot counter
// work-conserving by jumping to the next pending core when the current
// slot has no request. The default build is strict TDM.
module sspm_tdm_arbiter #(
  parameter int NCORES = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int MEM_AW = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NCORES-1:0]          io_req,
  input  logic [NCORES-1:0]          io_we,
  input  logic [NCORES*ADDR_W-1:0]   io_addr,
  input  logic [NCORES*DATA_W-1:0]   io_wdata,
  output logic [NCORES-1:0]          io_select,
  output logic [NCORES*DATA_W-1:0]   io_rdata
);

  localparam int SLOT_W = $clog2(NCORES);

  logic [SLOT_W-1:0]              r_slot;
  logic [NCORES-1:0]              r_pend;
  logic [NCORES-1:0]              r_we;
  logic [NCORES-1:0][MEM_AW-1:0]  r_addr;
  logic [NCORES-1:0][DATA_W-1:0]  r_wdata;
  logic [NCORES-1:0]              r_sel;
  logic [NCORES-1:0][DATA_W-1:0]  r_rdata;
  logic [DATA_W-1:0]              r_mem [2**MEM_AW];

  logic [NCORES-1:0]  w_cap;
  logic               w_srv;
  logic [NCORES-1:0]  w_srv_vec;
  logic [MEM_AW-1:0]  w_mem_idx;
  logic [SLOT_W-1:0]  w_slot_inc;
  logic [SLOT_W-1:0]  w_slot_nxt;
  logic               w_unused;

  // Only the word-index bits of each byte address are stored.
  assign w_unused  = ^io_addr;
  assign w_cap     = io_req & ~r_pend;
  assign w_srv     = r_pend[r_slot];
  assign w_mem_idx = r_addr[r_slot];
  assign io_select = r_sel;
  assign io_rdata  = r_rdata;

  // One-hot of the core being served at the coming edge (empty if its slot is idle).
  always_comb begin
    w_srv_vec         = '0;
    w_srv_vec[r_slot] = w_srv;
  end

`ifdef SSPM_SKIP_IDLE_EN
  logic [NCORES-1:0] w_pend_after;
  assign w_pend_after = (r_pend & ~w_srv_vec) | w_cap;
`endif

  // Slot selection: plain wrap-around increment, or skip ahead to the nearest
  // core that will be pending after this edge when the current slot is idle.
  always_comb begin
    w_slot_inc = (r_slot == SLOT_W'(NCORES - 1)) ? '0 : r_slot + SLOT_W'(1);
    w_slot_nxt = w_slot_inc;
`ifdef SSPM_SKIP_IDLE_EN
    if (!w_srv) begin
      for (int k = NCORES; k >= 1; k--) begin
        if (w_pend_after[(int'(r_slot) + k) % NCORES])
          w_slot_nxt = SLOT_W'((int'(r_slot) + k) % NCORES);
      end
    end
`endif
  end

  // Memory array is not reset; only the served core's write reaches it.
  always_ff @(posedge clk) begin
    if (w_srv && r_we[r_slot])
      r_mem[w_mem_idx] <= r_wdata[r_slot];
  end

  // Slot, pending bits, request latches, completion pulse and read-data lanes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_slot  <= '0;
      r_pend  <= '0;
      r_we    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_sel   <= '0;
      r_rdata <= '0;
    end else begin
      r_slot <= w_slot_nxt;
      // Capture needs pending=0 and clear needs pending=1, so they never collide.
      r_pend <= (r_pend & ~w_srv_vec) | w_cap;
      r_sel  <= w_srv_vec;
      for (int i = 0; i < NCORES; i++) begin
        if (w_cap[i]) begin
          r_we[i]    <= io_we[i];
          r_addr[i]  <= io_addr[i*ADDR_W+2 +: MEM_AW];
          r_wdata[i] <= io_wdata[i*DATA_W +: DATA_W];
        end
      end
      if (w_srv && !r_we[r_slot])
        r_rdata[r_slot] <= r_mem[w_mem_idx];
    end
  end

endmodule

// File: tb/tb_sspm_tdm_arbiter.sv
// Directed bench for sspm_tdm_arbiter with a completion scoreboard.
module tb_sspm_tdm_arbiter;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [N-1:0]      io_req = '0;
  logic [N-1:0]      io_we = '0;
  logic [N*AW-1:0]   io_addr = '0;
  logic [N*DW-1:0]   io_wdata = '0;
  logic [N-1:0]      io_select;
  logic [N*DW-1:0]   io_rdata;

  sspm_tdm_arbiter #(.NCORES(N), .ADDR_W(AW), .DATA_W(DW), .MEM_AW(10)) dut (
    .clk(clk), .reset(reset), .io_req(io_req), .io_we(io_we), .io_addr(io_addr),
    .io_wdata(io_wdata), .io_select(io_select), .io_rdata(io_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          core;
    logic [31:0] data;
    int          req_cyc;
    int          exp_cyc;
  } item_t;

  item_t       q[$];
  logic [31:0] mdl [int];
  logic [31:0] lastrd [N];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  // Cycle index since reset release; in strict TDM the slot equals cyc % N.
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic int exp_sel(input int c, input int core);
    int d;
    d = c + 1;
    while (d % N != core) d++;
    return d + 1;
  endfunction

  // Completion monitor: pop the oldest expectation for each pulsing core.
  always @(negedge clk) begin
    if (reset) begin
      total++;
      assert (!$isunknown(io_select) && $countones(io_select) <= 1)
      else begin bad++; $error("FAIL sel_onehot: got %b want at most one bit", io_select); end
      for (int i = 0; i < N; i++) begin
        if (io_select[i] === 1'b1) begin
          int    idx;
          item_t it;
          idx = -1;
          for (int j = 0; j < q.size(); j++)
            if (idx < 0 && q[j].core == i) idx = j;
          total++;
          assert (idx >= 0)
          else begin bad++; $error("FAIL unexpected_sel: core %0d pulsed at cyc %0d, want no pulse", i, cyc); end
          if (idx >= 0) begin
            it = q[idx];
            q.delete(idx);
            total++;
            assert (io_rdata[i*DW +: DW] === it.data)
            else begin bad++; $error("FAIL rdata%0d: got %h want %h", i, io_rdata[i*DW +: DW], it.data); end
            total++;
`ifdef SSPM_SKIP_IDLE_EN
            assert ((cyc - it.req_cyc) >= 2 && (cyc - it.req_cyc) <= N + 1)
            else begin bad++; $error("FAIL latency%0d: got %0d want 2..%0d", i, cyc - it.req_cyc, N + 1); end
`else
            assert (cyc === it.exp_cyc)
            else begin bad++; $error("FAIL sel_cyc%0d: got %0d want %0d", i, cyc, it.exp_cyc); end
`endif
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    io_req = '0;
  endtask

  task automatic issue(input int core, input logic we, input logic [15:0] addr,
                       input logic [31:0] wd, input bit accept);
    item_t it;
    int    w;
    io_req[core]            = 1'b1;
    io_we[core]             = we;
    io_addr[core*AW +: AW]  = addr;
    io_wdata[core*DW +: DW] = wd;
    if (accept) begin
      w          = (int'(addr) >> 2) & 1023;
      it.core    = core;
      it.req_cyc = cyc;
      it.exp_cyc = exp_sel(cyc, core);
      if (we) begin
        mdl[w]  = wd;
        it.data = lastrd[core];
      end else begin
        it.data = mdl[w];
      end
      lastrd[core] = it.data;
      q.push_back(it);
    end
  endtask

  task automatic align(input int s);
    int n;
    n = 0;
    while (cyc % N != s && n < 2 * N) begin tick(); n++; end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 40) begin tick(); n++; end
    total++;
    assert (q.size() == 0)
    else begin bad++; $error("FAIL drain: got %0d outstanding want 0", q.size()); end
  endtask

  initial begin
    for (int i = 0; i < N; i++) lastrd[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    assert (io_select === '0 && io_rdata === '0)
    else begin bad++; $error("FAIL reset_state: got sel=%b rdata=%h want 0", io_select, io_rdata); end
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Core 1 write while slot=0, then core 3 reads it back.
    align(0);
    issue(1, 1'b1, 16'h0010, 32'hDEADBEEF, 1'b1);
    tick();
    drain();
    issue(3, 1'b0, 16'h0010, 32'h0, 1'b1);
    tick();
    drain();

    // More writes, then aliased and misaligned reads of the same word.
    issue(0, 1'b1, 16'h0020, 32'h11111111, 1'b1);
    tick();
    drain();
    issue(2, 1'b1, 16'h1004, 32'hCAFEF00D, 1'b1);
    tick();
    drain();
    issue(0, 1'b0, 16'h0004, 32'h0, 1'b1);
    tick();
    drain();
    issue(1, 1'b0, 16'h8007, 32'h0, 1'b1);
    tick();
    drain();

    // All four cores read in the same cycle.
    align(1);
    issue(0, 1'b0, 16'h0020, 32'h0, 1'b1);
    issue(1, 1'b0, 16'h0010, 32'h0, 1'b1);
    issue(2, 1'b0, 16'h0004, 32'h0, 1'b1);
    issue(3, 1'b0, 16'h0020, 32'h0, 1'b1);
    tick();
    drain();

    // Core 2 requests while its own slot is current: full rotation.
    align(2);
    issue(2, 1'b0, 16'h0020, 32'h0, 1'b1);
    tick();
    drain();

    // Second request from core 0 while still pending is ignored.
    align(0);
    issue(0, 1'b0, 16'h0010, 32'h0, 1'b1);
    tick();
    issue(0, 1'b0, 16'h0020, 32'h0, 1'b0);
    tick();
    drain();
    repeat (6) tick();
    total++;
    assert (io_rdata[0 +: DW] === 32'hDEADBEEF)
    else begin bad++; $error("FAIL ignored_req: got %h want %h", io_rdata[0 +: DW], 32'hDEADBEEF); end

    // Reset while three reads are pending.
    align(0);
    issue(1, 1'b0, 16'h0010, 32'h0, 1'b0);
    issue(2, 1'b0, 16'h0020, 32'h0, 1'b0);
    issue(3, 1'b0, 16'h0004, 32'h0, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    total++;
    assert (io_select === '0 && io_rdata === '0)
    else begin bad++; $error("FAIL mid_reset: got sel=%b rdata=%h want 0", io_select, io_rdata); end
    q.delete();
    for (int i = 0; i < N; i++) lastrd[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick();
    // Slot restarts at 0, so this core-0 read lands at a fixed cycle.
    issue(0, 1'b0, 16'h0010, 32'h0, 1'b1);
    tick();
    drain();
    repeat (8) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
